// File: rtl/srv_mem_pkg.sv
// Shared definitions for the srv_mem line-refill path: default widths and
// the arbiter state encoding.
package srv_mem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/srv_rr_pick2.sv
// Combinational two-way picker: round-robin against last_grant when rr_en,
// otherwise port 0 wins a tie.
module srv_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic rr_en,
  output logic winner
);

  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = rr_en ? ~last_grant : 1'b0;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/srv_mem_arbiter.sv
// Two-port arbiter for the srv_mem line-refill port: one transaction in
// flight, response routed to the owner, watchdog abort for hung requests.
module srv_mem_arbiter
  import srv_mem_pkg::*;
#(
  parameter int   ADDR_W  = DEF_ADDR_W,
  parameter int   LINE_W  = DEF_LINE_W,
  parameter logic RR_EN   = 1'b1,
  parameter int   TIMEOUT = 64,
  parameter int   CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              rsp0_o,
  output logic              err0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              rsp1_o,
  output logic              err1_o,
  output logic [LINE_W-1:0] rdata_o,
  output logic              ext_req_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  input  logic              ext_rsp_i,
  input  logic [LINE_W-1:0] ext_data_i,
  output logic              busy_o,
  output logic              owner_o
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              ext_req_q, ext_req_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [1:0]        rsp_q, rsp_d;
  logic [1:0]        err_q, err_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
  logic              winner;

  srv_rr_pick2 u_pick (
    .req0       (req0_i),
    .req1       (req1_i),
    .last_grant (last_grant_q),
    .rr_en      (RR_EN),
    .winner     (winner)
  );

  always_comb begin
    state_d      = state_q;
    ext_req_d    = ext_req_q;
    ext_addr_d   = ext_addr_q;
    rsp_d        = 2'b00;
    err_d        = 2'b00;
    rdata_d      = rdata_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    case (state_q)
      ST_IDLE: begin
        // ext_rsp_i here is a stale response and is deliberately dropped
        if (req0_i || req1_i) begin
          owner_d      = winner;
          last_grant_d = winner;
          ext_addr_d   = winner ? addr1_i : addr0_i;
          ext_req_d    = 1'b1;
          wd_d         = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wd_d = wd_q + CNT_W'(1);
        if (ext_rsp_i) begin
          ext_req_d       = 1'b0;
          rdata_d         = ext_data_i;
          rsp_d[owner_q]  = 1'b1;
          state_d         = ST_RESP;
        end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
          ext_req_d       = 1'b0;
          rdata_d         = '0;
          err_d[owner_q]  = 1'b1;
          state_d         = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ext_req_q    <= 1'b0;
      ext_addr_q   <= '0;
      rsp_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      ext_req_q    <= ext_req_d;
      ext_addr_q   <= ext_addr_d;
      rsp_q        <= rsp_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
    end
  end

  assign rsp0_o     = rsp_q[0];
  assign rsp1_o     = rsp_q[1];
  assign err0_o     = err_q[0];
  assign err1_o     = err_q[1];
  assign rdata_o    = rdata_q;
  assign ext_req_o  = ext_req_q;
  assign ext_addr_o = ext_addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_srv_mem_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed priority,
// both with an 8-cycle watchdog and a bench-side memory model.
module tb_srv_mem_arbiter;

  typedef struct {
    int          inst;
    logic        port;
    logic [31:0] addr;
  } grant_t;

  typedef struct {
    int           inst;
    logic         port;
    logic         is_err;
    logic [127:0] data;
    int           cyc;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req0 [2];
  logic         req1 [2];
  logic [31:0]  addr0 [2];
  logic [31:0]  addr1 [2];
  logic         rsp0 [2];
  logic         rsp1 [2];
  logic         err0 [2];
  logic         err1 [2];
  logic [127:0] rdata [2];
  logic         ext_req [2];
  logic [31:0]  ext_addr [2];
  logic         ext_rsp [2];
  logic [127:0] ext_data [2];
  logic         busy [2];
  logic         owner [2];

  grant_t grant_q[$];
  resp_t  resp_q[$];
  int checks = 0;
  int fails  = 0;
  int mem_lat [2];
  int mem_cnt [2];
  int inject_req [2];
  int inject_done [2];
  int pulses_seen [2];
  int req_cyc [2];
  logic prev_req [2];
  logic [31:0] held_addr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      srv_mem_arbiter #(
        .ADDR_W(32), .LINE_W(128), .RR_EN((gi == 0) ? 1'b1 : 1'b0),
        .TIMEOUT(8), .CNT_W(7)
      ) u_dut (
        .clk(clk), .rst(rst),
        .req0_i(req0[gi]), .addr0_i(addr0[gi]), .rsp0_o(rsp0[gi]), .err0_o(err0[gi]),
        .req1_i(req1[gi]), .addr1_i(addr1[gi]), .rsp1_o(rsp1[gi]), .err1_o(err1[gi]),
        .rdata_o(rdata[gi]),
        .ext_req_o(ext_req[gi]), .ext_addr_o(ext_addr[gi]),
        .ext_rsp_i(ext_rsp[gi]), .ext_data_i(ext_data[gi]),
        .busy_o(busy[gi]), .owner_o(owner[gi])
      );
    end
  endgenerate

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1000_0001};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_txn(input int i, input logic port, input logic [31:0] addr,
                          input logic is_err, input int cyc);
    grant_t g;
    resp_t  r;
    g.inst = i; g.port = port; g.addr = addr;
    r.inst = i; r.port = port; r.is_err = is_err;
    r.data = is_err ? 128'd0 : line_of(addr);
    r.cyc  = cyc;
    grant_q.push_back(g);
    resp_q.push_back(r);
  endtask

  task automatic wait_pulses(input int i, input int target, input string tag);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (pulses_seen[i] >= target) break;
    end
    if (k == 300) begin
      checks++;
      fails++;
      $display("FAIL %s_wait: got %0d pulses expected %0d", tag, pulses_seen[i], target);
    end
  endtask

  // Single request on one port; req is dropped the cycle after the pulse.
  task automatic run_one(input int i, input logic port, input logic [31:0] addr,
                         input int lat, input logic is_err, input int cyc, input string tag);
    int base;
    base = pulses_seen[i];
    mem_lat[i] = lat;
    push_txn(i, port, addr, is_err, cyc);
    @(negedge clk);
    if (port) begin addr1[i] = addr; req1[i] = 1'b1; end
    else      begin addr0[i] = addr; req0[i] = 1'b1; end
    wait_pulses(i, base + 1, tag);
    @(negedge clk);
    req0[i] = 1'b0;
    req1[i] = 1'b0;
  endtask

  // Memory model: answers lat cycles after ext_req rises, or on injection.
  initial begin
    for (int i = 0; i < 2; i++) begin
      ext_rsp[i] = 1'b0; ext_data[i] = '0; mem_cnt[i] = 0; inject_done[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ext_rsp[i] = 1'b0;
        if (inject_req[i] != inject_done[i]) begin
          ext_rsp[i]     = 1'b1;
          ext_data[i]    = {4{32'hDEAD_BEEF}};
          inject_done[i] = inject_req[i];
        end else if (ext_req[i] === 1'b1 && mem_lat[i] >= 0) begin
          if (mem_cnt[i] == mem_lat[i] - 1) begin
            ext_rsp[i]  = 1'b1;
            ext_data[i] = line_of(ext_addr[i]);
          end
          mem_cnt[i]++;
        end else begin
          mem_cnt[i] = 0;
        end
      end
    end
  end

  // Monitor: pops expected grants and responses as the DUTs present them.
  initial begin
    logic [3:0] p;
    grant_t g;
    resp_t  e;
    for (int i = 0; i < 2; i++) begin
      prev_req[i] = 1'b0; req_cyc[i] = 0; pulses_seen[i] = 0; held_addr[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        req_cyc[i]++;
        if (ext_req[i] === 1'b1 && prev_req[i] === 1'b0) begin
          req_cyc[i] = 1;
          held_addr[i] = ext_addr[i];
          if (grant_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_grant: inst %0d got owner %0d expected no grant", i, owner[i]);
          end else begin
            g = grant_q.pop_front();
            chk("grant_inst", 128'(i), 128'(g.inst));
            chk("grant_owner", 128'(owner[i]), 128'(g.port));
            chk("grant_addr", 128'(ext_addr[i]), 128'(g.addr));
          end
        end else if (ext_req[i] === 1'b1) begin
          chk("addr_stable", 128'(ext_addr[i]), 128'(held_addr[i]));
        end
        prev_req[i] = ext_req[i];
        p = {err1[i], err0[i], rsp1[i], rsp0[i]};
        if (p !== 4'b0000 && !rst) begin
          pulses_seen[i]++;
          chk("exclusive", 128'($countones(p) <= 1), 128'(1));
          if (resp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_pulse: inst %0d got pulses %b expected none", i, p);
          end else begin
            e = resp_q.pop_front();
            chk("resp_inst", 128'(i), 128'(e.inst));
            chk("resp_port", 128'(rsp1[i] | err1[i]), 128'(e.port));
            chk("resp_is_err", 128'(err0[i] | err1[i]), 128'(e.is_err));
            chk("resp_rdata", rdata[i], e.data);
            chk("resp_latency", 128'(req_cyc[i]), 128'(e.cyc));
            chk("resp_ext_req_low", 128'(ext_req[i]), 128'(0));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; addr0[i] = '0; addr1[i] = '0;
      mem_lat[i] = 2; inject_req[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 128'(busy[i]), 128'(0));
      chk("rst_ext_req", 128'(ext_req[i]), 128'(0));
      chk("rst_ext_addr", 128'(ext_addr[i]), 128'(0));
      chk("rst_rdata", rdata[i], 128'(0));
      chk("rst_owner", 128'(owner[i]), 128'(0));
      chk("rst_pulses", 128'({err1[i], err0[i], rsp1[i], rsp0[i]}), 128'(0));
    end
    rst = 1'b0;

    // Round-robin, both held: 0,1,0,1
    base = pulses_seen[0];
    push_txn(0, 1'b0, 32'h100, 1'b0, 3);
    push_txn(0, 1'b1, 32'h200, 1'b0, 3);
    push_txn(0, 1'b0, 32'h100, 1'b0, 3);
    push_txn(0, 1'b1, 32'h200, 1'b0, 3);
    mem_lat[0] = 2;
    addr0[0] = 32'h100; addr1[0] = 32'h200;
    req0[0] = 1'b1; req1[0] = 1'b1;
    wait_pulses(0, base + 4, "rr");
    @(negedge clk);
    req0[0] = 1'b0; req1[0] = 1'b0;

    run_one(0, 1'b0, 32'h40, 3, 1'b0, 4, "single");

    // Fixed priority: port 1 starves until req0 drops
    base = pulses_seen[1];
    push_txn(1, 1'b0, 32'h100, 1'b0, 3);
    push_txn(1, 1'b0, 32'h100, 1'b0, 3);
    push_txn(1, 1'b0, 32'h100, 1'b0, 3);
    push_txn(1, 1'b1, 32'h200, 1'b0, 3);
    mem_lat[1] = 2;
    addr0[1] = 32'h100; addr1[1] = 32'h200;
    req0[1] = 1'b1; req1[1] = 1'b1;
    wait_pulses(1, base + 3, "fp");
    @(negedge clk);
    req0[1] = 1'b0;
    wait_pulses(1, base + 4, "fp_tail");
    @(negedge clk);
    req1[1] = 1'b0;

    // Watchdog abort, then a stale response that must be ignored
    run_one(0, 1'b1, 32'h300, -1, 1'b1, 9, "timeout");
    base = pulses_seen[0];
    repeat (5) @(negedge clk);
    inject_req[0]++;
    repeat (4) @(negedge clk);
    chk("stale_no_pulse", 128'(pulses_seen[0]), 128'(base));
    chk("stale_busy", 128'(busy[0]), 128'(0));
    chk("stale_ext_req", 128'(ext_req[0]), 128'(0));

    // Response on the watchdog's last cycle wins over the abort
    run_one(0, 1'b0, 32'h50, 8, 1'b0, 9, "same_cycle");

    // Reset while in WAIT
    mem_lat[0] = -1;
    begin
      grant_t g;
      g.inst = 0; g.port = 1'b0; g.addr = 32'h60;
      grant_q.push_back(g);
    end
    addr0[0] = 32'h60;
    req0[0] = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy[0] === 1'b1) break;
    end
    chk("rst_mid_went_busy", 128'(busy[0]), 128'(1));
    repeat (2) @(negedge clk);
    base = pulses_seen[0];
    rst = 1'b1;
    req0[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", 128'(busy[0]), 128'(0));
    chk("rst_mid_ext_req", 128'(ext_req[0]), 128'(0));
    chk("rst_mid_pulses", 128'({err1[0], err0[0], rsp1[0], rsp0[0]}), 128'(0));
    inject_req[0]++;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_pulse", 128'(pulses_seen[0]), 128'(base));
    run_one(0, 1'b1, 32'h700, 2, 1'b0, 3, "after_rst");

    repeat (5) @(negedge clk);
    chk("grant_q_empty", 128'(grant_q.size()), 128'(0));
    chk("resp_q_empty", 128'(resp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
